// File: rtl/anc_pkg.sv
// Shared constants for the FxLMS ANC sequencer: filter length, address width,
// update sub-cycle count, FSM state encoding and ring-address arithmetic.
package anc_pkg;

  localparam int ANC_N_TAPS  = 128;
  localparam int ANC_AW      = $clog2(ANC_N_TAPS);
  localparam int ANC_UPD_CYC = 3;

  // FSM state encoding
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_XWR  = 3'd1;
  localparam logic [2:0] S_FILT = 3'd2;
  localparam logic [2:0] S_FDRN = 3'd3;
  localparam logic [2:0] S_SEC  = 3'd4;
  localparam logic [2:0] S_SDRN = 3'd5;
  localparam logic [2:0] S_UPD  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  // Ring buffers are a power of two long, so AW-bit subtraction wraps mod N_TAPS.
  function automatic logic [ANC_AW-1:0] ring_sub(input logic [ANC_AW-1:0] ptr,
                                                 input logic [ANC_AW-1:0] off);
    return ptr - off;
  endfunction

endpackage

// File: rtl/anc_tap_cnt.sv
// Tap index k and update sub-cycle counter sc with end-of-range flags.
// In plain mode k advances every cycle; in sub-cycle mode k advances once per
// UPD_CYC cycles.
module anc_tap_cnt
  import anc_pkg::*;
#(
  parameter int N_TAPS  = ANC_N_TAPS,
  parameter int UPD_CYC = ANC_UPD_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              use_sc,
  output logic [ANC_AW-1:0] k,
  output logic [1:0]        sc,
  output logic              tap_end,
  output logic              sc_end
);

  localparam logic [ANC_AW-1:0] K_LAST  = ANC_AW'(N_TAPS - 1);
  localparam logic [1:0]        SC_LAST = 2'(UPD_CYC - 1);

  assign tap_end = (k == K_LAST);
  assign sc_end  = (sc == SC_LAST);

  // Counter advance; clr restarts both fields at the first cycle of each phase
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      k  <= '0;
      sc <= '0;
    end else if (use_sc) begin
      if (sc_end) begin
        sc <= '0;
        k  <= k + 1'b1;
      end else begin
        sc <= sc + 1'b1;
      end
    end else begin
      k <= k + 1'b1;
    end
  end

endmodule

// File: rtl/anc_fxlms_seq.sv
// FxLMS active-noise-control sequencer. Per reference sample it writes the
// reference ring, runs the FIR (weights x reference), the secondary-path
// filter (S-hat x reference) into the filtered-reference ring, then the LMS
// weight update over all taps, and finally advances the ring pointers.
module anc_fxlms_seq
  import anc_pkg::*;
#(
  parameter int N_TAPS  = ANC_N_TAPS,
  parameter int UPD_CYC = ANC_UPD_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_pedge,
  output logic [ANC_AW-1:0] xn_addr,
  output logic [ANC_AW-1:0] sn_addr,
  output logic [ANC_AW-1:0] wz_addr,
  output logic [ANC_AW-1:0] sh_addr,
  output logic              xn_wren,
  output logic              sn_wren,
  output logic              wz_wren,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              mac_sel,
  output logic              yn_load,
  output logic              upd_en,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [7:0]        ovr_cnt
);

  localparam int AW = ANC_AW;
  localparam logic [AW-1:0] K_ONE = AW'(1);

  logic [2:0]    state, state_nx;
  logic [AW-1:0] xn_ptr, sn_ptr;
  logic [AW-1:0] k;
  logic [1:0]    sc;
  logic          tap_end, sc_end;
  logic          cnt_clr, cnt_use_sc;
  logic          mac_en_p1;
  logic          ovr_p1;
  logic [AW-1:0] xk_addr, sk_addr;

  // Saturating 8-bit increment for the overrun counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign xk_addr = ring_sub(xn_ptr, k);
  assign sk_addr = ring_sub(sn_ptr, k);

  anc_tap_cnt #(
    .N_TAPS  (N_TAPS),
    .UPD_CYC (UPD_CYC)
  ) u_tap_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .use_sc  (cnt_use_sc),
    .k       (k),
    .sc      (sc),
    .tap_end (tap_end),
    .sc_end  (sc_end)
  );

  // Counter restarts on every phase change and is held at zero while idle
  assign cnt_clr    = (state_nx != state) || (state == S_IDLE);
  assign cnt_use_sc = (state == S_UPD);

  // Next-state sequencing; drains are two cycles (k = 0, 1)
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start_pedge) state_nx = S_XWR;
      S_XWR:  state_nx = S_FILT;
      S_FILT: if (tap_end) state_nx = S_FDRN;
      S_FDRN: if (k == K_ONE) state_nx = S_SEC;
      S_SEC:  if (tap_end) state_nx = S_SDRN;
      S_SDRN: if (k == K_ONE) state_nx = S_UPD;
      S_UPD:  if (tap_end && sc_end) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register and ring pointers; pointers advance once per finished frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      xn_ptr <= '0;
      sn_ptr <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DONE) begin
        xn_ptr <= xn_ptr + 1'b1;
        sn_ptr <= sn_ptr + 1'b1;
      end
    end
  end

  // Stage p1: MAC enable trails each address cycle by the RAM read latency;
  // overrun flags a strobe that arrived while a frame was in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mac_en_p1 <= 1'b0;
      ovr_p1    <= 1'b0;
      ovr_cnt   <= 8'd0;
    end else begin
      mac_en_p1 <= (state == S_FILT) || (state == S_SEC);
      ovr_p1    <= start_pedge && (state != S_IDLE);
      if (start_pedge && (state != S_IDLE))
        ovr_cnt <= sat_inc8(ovr_cnt);
    end
  end

  assign mac_en  = mac_en_p1;
  assign overrun = ovr_p1;
  assign busy    = (state != S_IDLE);

  // Per-state address and strobe decode; everything not driven stays zero
  always_comb begin
    xn_addr = '0;
    sn_addr = '0;
    wz_addr = '0;
    sh_addr = '0;
    xn_wren = 1'b0;
    sn_wren = 1'b0;
    wz_wren = 1'b0;
    mac_clr = 1'b0;
    mac_sel = 1'b0;
    yn_load = 1'b0;
    upd_en  = 1'b0;
    done    = 1'b0;
    case (state)
      S_XWR: begin
        xn_wren = 1'b1;
        xn_addr = xn_ptr;
      end
      S_FILT: begin
        xn_addr = xk_addr;
        wz_addr = k;
        mac_clr = (k == '0);
      end
      S_FDRN: yn_load = (k == K_ONE);
      S_SEC: begin
        xn_addr = xk_addr;
        sh_addr = k;
        mac_sel = 1'b1;
        mac_clr = (k == '0);
      end
      S_SDRN: begin
        if (k == K_ONE) begin
          sn_wren = 1'b1;
          sn_addr = sn_ptr;
        end
      end
      S_UPD: begin
        wz_addr = k;
        if (sc == 2'd0) sn_addr = sk_addr;
        if (sc == 2'd1) upd_en = 1'b1;
        if (sc_end)     wz_wren = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_anc_fxlms_seq.sv
// Scoreboard bench for anc_fxlms_seq: stimulus pushes expected strobe events
// (cycle and address) into per-kind queues, a negedge monitor pops and compares.
module tb_anc_fxlms_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_pedge;
  logic [6:0] xn_addr, sn_addr, wz_addr, sh_addr;
  logic       xn_wren, sn_wren, wz_wren;
  logic       mac_clr, mac_en, mac_sel, yn_load, upd_en;
  logic       busy, done, overrun;
  logic [7:0] ovr_cnt;

  anc_fxlms_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_pedge (start_pedge),
    .xn_addr     (xn_addr),
    .sn_addr     (sn_addr),
    .wz_addr     (wz_addr),
    .sh_addr     (sh_addr),
    .xn_wren     (xn_wren),
    .sn_wren     (sn_wren),
    .wz_wren     (wz_wren),
    .mac_clr     (mac_clr),
    .mac_en      (mac_en),
    .mac_sel     (mac_sel),
    .yn_load     (yn_load),
    .upd_en      (upd_en),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .ovr_cnt     (ovr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  localparam int K_XWR = 0, K_YLD = 1, K_SWR = 2, K_WWR = 3, K_DONE = 4, K_OVR = 5;

  ev_t q_xwr[$], q_yld[$], q_swr[$], q_wwr[$], q_done[$], q_ovr[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;
  int exp_ptr = 0;
  int exp_ovr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int kind, input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    case (kind)
      K_XWR:  q_xwr.push_back(e);
      K_YLD:  q_yld.push_back(e);
      K_SWR:  q_swr.push_back(e);
      K_WWR:  q_wwr.push_back(e);
      K_DONE: q_done.push_back(e);
      default: q_ovr.push_back(e);
    endcase
  endtask

  task automatic observe(input string nm, input int kind, input int val);
    ev_t e;
    bit  have;
    have = 1'b0;
    e.cyc = 0;
    e.val = 0;
    case (kind)
      K_XWR:  if (q_xwr.size()  > 0) begin e = q_xwr.pop_front();  have = 1'b1; end
      K_YLD:  if (q_yld.size()  > 0) begin e = q_yld.pop_front();  have = 1'b1; end
      K_SWR:  if (q_swr.size()  > 0) begin e = q_swr.pop_front();  have = 1'b1; end
      K_WWR:  if (q_wwr.size()  > 0) begin e = q_wwr.pop_front();  have = 1'b1; end
      K_DONE: if (q_done.size() > 0) begin e = q_done.pop_front(); have = 1'b1; end
      default: if (q_ovr.size() > 0) begin e = q_ovr.pop_front();  have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s unexpected at cycle %0d (val %0d), expected no event", nm, cyc, val);
    end else if (e.cyc != cyc || e.val != val) begin
      errors++;
      $display("FAIL %s got cycle %0d val %0d, expected cycle %0d val %0d", nm, cyc, val, e.cyc, e.val);
    end
  endtask

  // Monitor: every strobe the DUT presents is matched against the scoreboard
  always @(negedge clk) begin
    if (mon_on) begin
      if (xn_wren === 1'b1) observe("xn_wren", K_XWR, int'(xn_addr));
      if (yn_load === 1'b1) observe("yn_load", K_YLD, 0);
      if (sn_wren === 1'b1) observe("sn_wren", K_SWR, int'(sn_addr));
      if (wz_wren === 1'b1) observe("wz_wren", K_WWR, int'(wz_addr));
      if (done    === 1'b1) observe("done",    K_DONE, 0);
      if (overrun === 1'b1) observe("overrun", K_OVR, int'(ovr_cnt));
    end
  end

  function automatic logic [46:0] all_outs();
    return {xn_addr, sn_addr, wz_addr, sh_addr, xn_wren, sn_wren, wz_wren,
            mac_clr, mac_en, mac_sel, yn_load, upd_en, busy, done, overrun, ovr_cnt};
  endfunction

  // One frame starting at the current negedge (t=0 is cycle c0).
  // oa/ob: extra strobes (overruns); sat_n: strobes at t=1..sat_n; rst_t: mid-frame reset.
  task automatic frame(input int p, input int oa, input int ob, input int sat_n, input int rst_t);
    int c0, last, cut;
    c0   = cyc;
    last = (rst_t >= 0) ? rst_t + 1 : 647;
    cut  = (rst_t >= 0) ? c0 + rst_t : c0 + 646;
    if (c0 + 1 <= cut)   push(K_XWR, c0 + 1, p);
    if (c0 + 131 <= cut) push(K_YLD, c0 + 131, 0);
    if (c0 + 261 <= cut) push(K_SWR, c0 + 261, p);
    for (int k = 0; k < 128; k++)
      if (c0 + 264 + 3 * k <= cut) push(K_WWR, c0 + 264 + 3 * k, k);
    if (c0 + 646 <= cut) push(K_DONE, c0 + 646, 0);

    for (int t = 0; t <= last; t++) begin
      start_pedge = (t == 0) || (t == oa) || (t == ob) || (t >= 1 && t <= sat_n);
      rst_n       = (t != rst_t);
      if (start_pedge && t != 0) begin
        exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
        push(K_OVR, c0 + t + 1, exp_ovr);
      end
      if (rst_t < 0 || t < rst_t) begin
        case (t)
          0:   chk("busy_idle", busy, 1'b0);
          1:   begin chk("busy_c1", busy, 1'b1); chk("xwr_addr", xn_addr, p); end
          2:   begin chk("filt_clr", mac_clr, 1'b1); chk("filt_sel", mac_sel, 1'b0);
                     chk("filt_wz0", wz_addr, 0); chk("mac_en_c2", mac_en, 1'b0); end
          3:   begin chk("mac_en_c3", mac_en, 1'b1); chk("filt_clr_k1", mac_clr, 1'b0); end
          7:   begin chk("filt_xaddr_k5", xn_addr, (p + 128 - 5) % 128); chk("filt_wz5", wz_addr, 5);
                     if (p == 3) chk("wrap_xaddr_126", xn_addr, 126); end
          130: chk("mac_en_c130", mac_en, 1'b1);
          131: chk("mac_en_c131", mac_en, 1'b0);
          132: begin chk("sec_clr", mac_clr, 1'b1); chk("sec_sel", mac_sel, 1'b1);
                     chk("sec_sh0", sh_addr, 0); chk("sec_xaddr", xn_addr, p); end
          260: begin chk("mac_en_c260", mac_en, 1'b1); chk("sdrn_sel", mac_sel, 1'b0); end
          262: begin chk("upd_sn_k0", sn_addr, p); chk("upd_wz_k0", wz_addr, 0); chk("upd_en_sc0", upd_en, 1'b0); end
          263: chk("upd_en_sc1", upd_en, 1'b1);
          274: begin chk("upd_sn_k4", sn_addr, (p + 128 - 4) % 128);
                     if (p == 3) chk("wrap_saddr_127", sn_addr, 127); end
          646: chk("busy_c646", busy, 1'b1);
          647: begin chk("busy_c647", busy, 1'b0); chk("ovr_cnt", ovr_cnt, exp_ovr);
                     if (oa == 300 && ob == 646) chk("ovr_cnt_two", ovr_cnt, 2);
                     if (sat_n >= 255) chk("ovr_cnt_sat", ovr_cnt, 255); end
          default: ;
        endcase
      end
      if (rst_t >= 0 && t == rst_t + 1) chk("outs_after_reset", all_outs(), '0);
      @(negedge clk);
    end
    start_pedge = 1'b0;
    rst_n       = 1'b1;
    if (rst_t >= 0) begin
      exp_ptr = 0;
      exp_ovr = 0;
    end else begin
      exp_ptr = (exp_ptr + 1) % 128;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start_pedge = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), '0);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);

    // Frame 0 with overruns at c300 and coincident with done at c646
    frame(exp_ptr, 300, 646, 0, -1);
    // Frames 1..128; frame 3 exercises address wrap, frame 128 pointer wrap back to 0
    for (int f = 1; f <= 128; f++) frame(exp_ptr, -1, -1, 0, -1);
    // Reset at c400 abandons the frame
    frame(exp_ptr, -1, -1, 0, 400);
    // Next frame restarts at pointer 0 and absorbs 300 overrun strobes
    frame(exp_ptr, -1, -1, 300, -1);

    repeat (5) @(negedge clk);
    chk("q_xwr_empty",  q_xwr.size(),  0);
    chk("q_yld_empty",  q_yld.size(),  0);
    chk("q_swr_empty",  q_swr.size(),  0);
    chk("q_wwr_empty",  q_wwr.size(),  0);
    chk("q_done_empty", q_done.size(), 0);
    chk("q_ovr_empty",  q_ovr.size(),  0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/anc_fxlms_seq.md
ANC_FXLMS_SEQ -- requirements
Module: anc_fxlms_seq

Interface
REQ-001 SHALL have parameter N_TAPS, default 128, meaning filter length for all three buffers; the address width is AW = log2(N_TAPS) = 7.
REQ-002 SHALL have parameter UPD_CYC, default 3, meaning cycles per weight-update tap; fixed at 3.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start_pedge, input, 1 bit: one-cycle strobe meaning a new reference sample is available.
REQ-006 SHALL have outputs xn_addr, sn_addr, wz_addr and sh_addr, AW bits each: addresses for the reference ring, the filtered-reference ring, the weight RAM and the secondary-path coefficient ROM.
REQ-007 SHALL have outputs xn_wren, sn_wren and wz_wren, 1 bit each: one-cycle RAM write enables.
REQ-008 SHALL have outputs mac_clr, mac_en, mac_sel (0=FILT, 1=SEC), yn_load and upd_en, 1 bit each: datapath controls.
REQ-009 SHALL have outputs busy, done and overrun, 1 bit each, plus ovr_cnt, 8 bits: status.

Function
REQ-010 SHALL implement the states IDLE, XWR, FILT, FDRN, SEC, SDRN, UPD and DONE.
REQ-011 SHALL hold registered pointers xn_ptr and sn_ptr (AW bits) plus tap index k (AW bits) and sub-cycle counter sc (2 bits).
REQ-012 SHALL, when in IDLE with start_pedge=1 at cycle c0, move to XWR; start_pedge outside IDLE is ignored for sequencing.
REQ-013 SHALL, in XWR (c1, 1 cycle), drive xn_wren=1 and xn_addr=xn_ptr.
REQ-014 SHALL, in FILT (c2..c129, k=0..127), drive xn_addr=(xn_ptr-k) mod N_TAPS, wz_addr=k and mac_sel=0, with mac_clr=1 only at k=0.
REQ-015 SHALL assert mac_en exactly one cycle after each FILT or SEC address cycle, to cover the 1-cycle registered RAM read latency.
REQ-016 SHALL, in FDRN (c130..c131), drive mac_en=1 at c130 (last tap) and yn_load=1 at c131.
REQ-017 SHALL, in SEC (c132..c259), drive xn_addr=(xn_ptr-k) mod N_TAPS, sh_addr=k and mac_sel=1, with mac_clr=1 only at k=0.
REQ-018 SHALL, in SDRN (c260..c261), drive mac_en=1 at c260, and at c261 drive sn_wren=1 with sn_addr=sn_ptr.
REQ-019 SHALL, in UPD (c262..c645), run 128 taps x 3 sub-cycles: sc=0 drives wz_addr=k and sn_addr=(sn_ptr-k) mod N_TAPS (read); sc=1 drives upd_en=1; sc=2 drives wz_wren=1 with wz_addr=k.
REQ-020 SHALL, in DONE (c646), pulse done=1, increment xn_ptr and sn_ptr mod N_TAPS (127 wraps to 0), and return to IDLE at c647.
REQ-021 SHALL drive busy=1 in every state except IDLE (c1..c646).
REQ-022 SHALL, when start_pedge=1 in any state other than IDLE, pulse overrun=1 on the next cycle and increment ovr_cnt, saturating at 255.
REQ-023 SHALL leave every write enable and datapath control at 0 in any cycle not named in REQ-013..REQ-020.
REQ-024 SHALL accept start_pedge coincident with done (state DONE) as an overrun; a new sample is accepted only from c647.
REQ-025 SHALL wrap all address subtraction modulo N_TAPS (e.g. xn_ptr=3, k=5 gives addr 126).

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, force state IDLE, xn_ptr=sn_ptr=k=sc=0, ovr_cnt=0, and all 1-bit outputs and addresses to 0.
REQ-027 SHALL, on reset asserted mid-operation, abandon the frame with no further write enables, and the next start_pedge begins at XWR with the pointers at 0.

Structure
REQ-028 SHALL take N_TAPS, AW, UPD_CYC and the state encoding from the shared package anc_pkg.
REQ-029 SHALL place the k/sc counter, with its tap-end and sub-cycle-end flags, in the sub-module anc_tap_cnt.

Verification
REQ-030 SHALL cover a single frame: start_pedge at c0 -> xn_wren at c1, yn_load at c131, sn_wren at c261, 128 wz_wren pulses at c264+3k, done at c646, busy high c1..c646.
REQ-031 SHALL cover address wrap: preload xn_ptr=3 via 3 frames -> in FILT k=5, xn_addr=126, and sn_addr at UPD k=4 is 127.
REQ-032 SHALL cover pointer wrap: 128 frames -> xn_ptr and sn_ptr both return to 0 after the 128th done.
REQ-033 SHALL cover overrun: start_pedge at c300 and c646 -> overrun pulses at c301 and c647, ovr_cnt=2, and the frame timing is unchanged.
REQ-034 SHALL cover mid-frame reset: rst_n=0 at c400 -> all outputs 0 at c401, no wz_wren afterwards, and the next frame's xn_addr at XWR is 0.
REQ-035 SHALL cover saturation: 300 overrun strobes -> ovr_cnt holds 255.
